// File: rtl/xy_frame_streamer.sv
// Double-buffered point memory streamed as NCH parallel serial lines: START, two header
// bytes, the active point list (looping or one-shot), then STOP; slots advance when scl==0.
module xy_frame_streamer #(
  parameter int         DW   = 8,
  parameter int         AW   = 11,
  parameter int         NCH  = 2,
  parameter logic [7:0] HDR0 = 8'h90,
  parameter logic [7:0] HDR1 = 8'h40
) (
  input  logic              clk,
  input  logic              Not_Rst,
  input  logic              scl,
  input  logic              en,
  input  logic              one_shot,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AW-1:0]     wr_addr,
  input  logic [NCH*DW-1:0] wr_data,
  input  logic              swap_req,
  input  logic [AW:0]       wr_len,
  output logic [NCH-1:0]    sda,
  output logic              busy,
  output logic              frame_done
);
  localparam int          WMAX    = (DW > 8) ? DW : 8;
  localparam int          BW      = $clog2(WMAX + 1);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(2**AW);

  typedef enum logic [2:0] {S_IDLE, S_START, S_HDR0, S_HDR1, S_POINTS, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              bank_q, bank_d;
  logic              pend_q, pend_d;
  logic [AW:0]       alen_q, alen_d;
  logic [AW:0]       slen_q, slen_d;
  logic [NCH-1:0]    sda_q, sda_d;
  logic              busy_q, fd_q, fd_d;

  logic [NCH*DW-1:0] mem0 [2**AW];
  logic [NCH*DW-1:0] mem1 [2**AW];

  logic [AW:0]       nlen;
  logic [BW-1:0]     wlen;
  logic [NCH*DW-1:0] rd_word;
  logic [7:0]        hdr;
  logic [DW-1:0]     ch;

  assign wr_ready   = ~pend_q;
  assign sda        = sda_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;

  // bank_q==0 means mem0 is active, so writes land in mem1
  always_ff @(posedge clk) begin
    if (wr_valid && wr_ready) begin
      if (bank_q) mem0[wr_addr] <= wr_data;
      else        mem1[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!Not_Rst) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      idx_q   <= '0;
      bank_q  <= 1'b0;
      pend_q  <= 1'b0;
      alen_q  <= '0;
      slen_q  <= '0;
      sda_q   <= '1;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      bank_q  <= bank_d;
      pend_q  <= pend_d;
      alen_q  <= alen_d;
      slen_q  <= slen_d;
      sda_q   <= sda_d;
      busy_q  <= (state_d != S_IDLE);
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    bank_d  = bank_q;
    pend_d  = pend_q;
    alen_d  = alen_q;
    slen_d  = slen_q;
    sda_d   = sda_q;
    fd_d    = 1'b0;
    nlen    = alen_q;
    rd_word = '0;
    hdr     = '0;
    ch      = '0;
    wlen    = (state_q == S_POINTS) ? BW'(DW) : BW'(8);

    if (swap_req && !pend_q) begin
      pend_d = 1'b1;
      slen_d = (wr_len > LEN_MAX) ? LEN_MAX : wr_len;
    end
    if (state_q == S_IDLE && pend_q) begin
      bank_d = ~bank_q;
      alen_d = slen_q;
      pend_d = 1'b0;
    end

    if (!scl) begin
      unique case (state_q)
        S_IDLE:  if (en && alen_q != '0) state_d = S_START;
        S_START: begin
          state_d = S_HDR0;
          bit_d   = '0;
        end
        S_HDR0, S_HDR1, S_POINTS: begin
          if (bit_q != wlen) begin
            bit_d = bit_q + 1'b1;
          end else begin
            bit_d = '0;
            if (state_q == S_HDR0) begin
              state_d = S_HDR1;
            end else if (state_q == S_HDR1) begin
              state_d = S_POINTS;
              idx_d   = '0;
            end else if (({1'b0, idx_q} + 1'b1) != alen_q) begin
              idx_d = idx_q + 1'b1;
            end else begin
              // Frame boundary: a pending swap lands here, before the loop/stop decision
              fd_d  = 1'b1;
              idx_d = '0;
              if (pend_q) begin
                bank_d = ~bank_q;
                alen_d = slen_q;
                pend_d = 1'b0;
                nlen   = slen_q;
              end
              if (nlen == '0 || one_shot || !en) state_d = S_STOP;
            end
          end
        end
        S_STOP: begin
          if (bit_q == '0) begin
            bit_d = BW'(1);
          end else begin
            state_d = S_IDLE;
            bit_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Line value for the slot being entered
      rd_word = bank_d ? mem1[idx_d] : mem0[idx_d];
      unique case (state_d)
        S_START: sda_d = '0;
        S_HDR0, S_HDR1: begin
          hdr   = (state_d == S_HDR0) ? HDR0 : HDR1;
          hdr   = hdr << bit_d;
          sda_d = (bit_d == BW'(8)) ? '1 : {NCH{hdr[7]}};
        end
        S_POINTS: begin
          for (int c = 0; c < NCH; c++) begin
            ch       = rd_word[c*DW +: DW];
            ch       = ch << bit_d;
            sda_d[c] = (bit_d == BW'(DW)) ? 1'b1 : ch[DW-1];
          end
        end
        S_STOP:  sda_d = (bit_d == '0) ? '0 : '1;
        default: sda_d = '1;
      endcase
    end
  end
endmodule

// File: tb/tb_xy_frame_streamer.sv
// Scoreboard bench: expected line slots are queued as each scenario is set up and
// popped by a monitor on every slot the DUT emits while busy.
module tb_xy_frame_streamer;
  localparam int AW = 11;

  logic        clk = 0, Not_Rst = 0, scl = 0, en = 0, one_shot = 0;
  logic        wr_valid = 0, swap_req = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [AW:0] wr_len = '0;
  logic        wr_ready, busy, frame_done;
  logic [1:0]  sda;

  logic [2:0]  exp_q[$];
  logic [15:0] cur_pts[$];
  int          n_cmp = 0, n_err = 0, fd_seen = 0, fd_exp = 0;
  bit          mon_on = 0, scl_tog = 0, fd_pend = 0;

  xy_frame_streamer dut (
    .clk(clk), .Not_Rst(Not_Rst), .scl(scl), .en(en), .one_shot(one_shot),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .wr_len(wr_len), .sda(sda), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) scl = scl_tog ? ~scl : 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_slot(input logic [1:0] v);
    exp_q.push_back({fd_pend, v});
    fd_pend = 0;
  endtask

  task automatic push_word(input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 7; i >= 0; i--) push_slot({b1[i], b0[i]});
    push_slot(2'b11);
  endtask

  task automatic push_head();
    push_slot(2'b00);
    push_word(8'h90, 8'h90);
    push_word(8'h40, 8'h40);
  endtask

  task automatic push_pts();
    foreach (cur_pts[k]) push_word(cur_pts[k][7:0], cur_pts[k][15:8]);
    fd_pend = 1;
    fd_exp++;
  endtask

  task automatic push_stop();
    push_slot(2'b00);
    push_slot(2'b11);
  endtask

  always @(posedge clk) begin
    logic       sc, rn;
    logic [1:0] prev;
    logic [2:0] e;
    sc = scl;
    rn = Not_Rst;
    prev = sda;
    #1;
    if (mon_on && rn) begin
      if (sc) begin
        check("sda_hold", sda, prev);
        check("fd_on_scl1", frame_done, 0);
      end else if (busy) begin
        if (frame_done) fd_seen++;
        if (exp_q.size() == 0) begin
          check("queue_empty", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("sda_slot", sda, e[1:0]);
          check("fd_slot", frame_done, e[2]);
        end
      end
    end
  end

  task automatic wait_busy(input logic lvl, input int lim, input string tag);
    int n = 0;
    while (busy !== lvl && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, lvl);
  endtask

  task automatic wait_fd(input int target, input int lim, input string tag);
    int n = 0;
    while (fd_seen < target && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, fd_seen >= target, 1);
  endtask

  task automatic wr_pt(input int a, input logic [15:0] d);
    wr_valid = 1;
    wr_addr  = AW'(a);
    wr_data  = d;
    @(negedge clk);
    wr_valid = 0;
  endtask

  task automatic do_swap(input int len);
    swap_req = 1;
    wr_len   = (AW+1)'(len);
    @(negedge clk);
    swap_req = 0;
  endtask

  task automatic finish_frame(input string tag);
    wait_busy(0, 20000, {tag, "_end"});
    check({tag, "_fd_cnt"}, fd_seen, fd_exp);
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sda", sda, 2'b11);
    check("rst_busy", busy, 0);
    check("rst_fd", frame_done, 0);
    check("rst_rdy", wr_ready, 1);
    Not_Rst = 1;
    mon_on  = 1;

    // Basic one-shot frame
    wr_pt(0, 16'h3412);
    wr_pt(1, 16'h7856);
    do_swap(2);
    @(negedge clk);
    cur_pts = {16'h3412, 16'h7856};
    push_head(); push_pts(); push_stop();
    one_shot = 1; en = 1;
    wait_busy(1, 10, "basic_start");
    en = 0;
    finish_frame("basic");

    // Looping without header resend; en dropped during the third frame
    push_head(); push_pts(); push_pts(); push_pts(); push_stop();
    one_shot = 0; en = 1;
    wait_fd(fd_seen + 2, 200, "loop_fd2");
    en = 0;
    finish_frame("loop");

    // Deferred swap issued mid-frame
    push_head(); push_pts();
    cur_pts = {16'hB2A1, 16'hD4C3, 16'hF6E5};
    push_pts(); push_stop();
    one_shot = 0; en = 1;
    wait_busy(1, 10, "defer_start");
    repeat (8) @(negedge clk);
    wr_pt(0, 16'hB2A1);
    wr_pt(1, 16'hD4C3);
    wr_valid = 1; wr_addr = 2; wr_data = 16'hF6E5;
    swap_req = 1; wr_len = 3;
    @(negedge clk);
    wr_valid = 0; swap_req = 0;
    check("defer_rdy_lo", wr_ready, 0);
    do_swap(1);
    wr_pt(0, 16'hDEAD);
    check("defer_rdy_hold", wr_ready, 0);
    wait_fd(fd_seen + 1, 100, "defer_fd1");
    check("defer_rdy_hi", wr_ready, 1);
    en = 0;
    finish_frame("defer");

    // Same one-shot frame with scl toggling every clock
    push_head(); push_pts(); push_stop();
    scl_tog = 1; one_shot = 1; en = 1;
    wait_busy(1, 10, "gate_start");
    en = 0;
    finish_frame("gate");
    scl_tog = 0;
    @(negedge clk);

    // Reset during a point word, then re-enable with nothing committed
    mon_on = 0;
    one_shot = 1; en = 1;
    wait_busy(1, 10, "rst_start");
    repeat (25) @(negedge clk);
    Not_Rst = 0; en = 0;
    @(negedge clk);
    check("midrst_sda", sda, 2'b11);
    check("midrst_busy", busy, 0);
    check("midrst_fd", frame_done, 0);
    check("midrst_rdy", wr_ready, 1);
    Not_Rst = 1; en = 1;
    repeat (20) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_sda", sda, 2'b11);
    en = 0;
    fd_seen = 0; fd_exp = 0;
    mon_on = 1;

    // Oversized length clamps to a full bank
    cur_pts = {};
    for (int i = 0; i < 2**AW; i++) begin
      wr_pt(i, {i[7:0] ^ 8'h5A, i[7:0]});
      cur_pts.push_back({i[7:0] ^ 8'h5A, i[7:0]});
    end
    do_swap(2**AW + 5);
    @(negedge clk);
    push_head(); push_pts(); push_stop();
    one_shot = 1; en = 1;
    wait_busy(1, 10, "clamp_start");
    en = 0;
    finish_frame("clamp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/xy_frame_streamer.md
XY_FRAME_STREAMER -- requirements
Module: xy_frame_streamer

Interface
REQ-001 Parameters SHALL be, one per line:
- DW, 8, point sample width in bits.
- AW, 11, point address width; frame depth is 2**AW.
- NCH, 2, number of serial channels (X, Y, ...).
- HDR0, 8'h90, first header byte (device address).
- HDR1, 8'h40, second header byte (control).
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all logic on rising edge.
- Not_Rst  in  1  synchronous active-low reset.
- scl  in  1  bit-slot qualifier; the block advances one bit slot on each clk edge where scl==0.
- en  in  1  streaming enable.
- one_shot  in  1  1 = send one frame then STOP; 0 = loop points forever.
- wr_valid  in  1  point write request.
- wr_ready  out  1  point write accept.
- wr_addr  in  AW  point index.
- wr_data  in  NCH*DW  channel c sample in bits [c*DW +: DW].
- swap_req  in  1  one-cycle pulse; commits the shadow bank with length wr_len.
- wr_len  in  AW+1  number of valid points in the shadow bank.
- sda  out  NCH  serial data lines, one per channel.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last point slot of a frame.

Function
REQ-003 Storage SHALL be two banks (active and shadow), each 2**AW x NCH*DW; the serializer reads only the active bank.
REQ-004 A write SHALL occur on a cycle with wr_valid && wr_ready, to shadow[wr_addr].
REQ-005 wr_ready SHALL be 1 except while a swap is pending.
REQ-006 swap_req SHALL:
- set swap_pending;
- latch len_shadow = min(wr_len, 2**AW).
REQ-007 A pending swap SHALL take effect at the frame boundary (the cycle frame_done pulses), or immediately if in IDLE: banks exchange, active_len <= len_shadow, swap_pending clears.
REQ-008 swap_req while swap_pending SHALL be ignored.
REQ-009 FSM states SHALL be IDLE, START, HDR0, HDR1, POINTS, STOP. Transitions advance only on scl==0 slots.
REQ-010 IDLE: all sda=1. Go to START when en==1 && active_len>0.
REQ-011 START: one slot with all sda=0.
REQ-012 Word framing: each word occupies W+1 slots. Bits are sent MSB first on slots 0..W-1; slot W is the ack slot with sda=1. W=8 for header bytes and W=DW for points.
REQ-013 HDR0 and HDR1 SHALL drive the same header byte on all channels.
REQ-014 POINTS: channel c sends active[idx][c*DW +: DW]. idx runs 0..active_len-1.
REQ-015 After the ack slot of idx==active_len-1, frame_done SHALL pulse for one clk and idx SHALL reset to 0. Then:
- if one_shot==1, go to STOP;
- if one_shot==0 and en==1, stay in POINTS (no header resend);
- if en==0, go to STOP.
REQ-016 If active_len becomes 0 at a swap, the FSM SHALL go to STOP.
REQ-017 STOP: slot 0 drives sda=0, slot 1 drives sda=1, then IDLE.
REQ-018 en deasserting mid-frame SHALL NOT truncate the frame; it is honoured at the frame boundary.
REQ-019 sda, busy and frame_done SHALL be registered. sda changes only on scl==0 cycles; it is stable while scl==1.
REQ-020 Bit counter and idx SHALL be wide enough for DW+1 slots and 2**AW points; there is no wrap before active_len.
REQ-021 Simultaneous write and swap_req SHALL perform the write first; the swap includes that write.

Reset
REQ-022 When Not_Rst==0 at a clk edge, the following SHALL hold:
- state=IDLE, sda=all 1, busy=0, frame_done=0, wr_ready=1;
- swap_pending=0, active_len=0, len_shadow=0, idx=0, bit counter=0, bank 0 active.
REQ-023 Memory contents SHALL NOT be cleared by reset.
REQ-024 Reset mid-frame SHALL abort without a STOP sequence; lines return to 1 on the next edge.

Verification
REQ-025 Basic stream:
- Stimulus: NCH=2, DW=8; write points (0x12,0x34),(0x56,0x78); wr_len=2; swap; en=1; one_shot=1; scl held 0.
- Response: ch0 = START 0, 10010000 1, 01000000 1, 00010010 1, 01010110 1, STOP 0 1; frame_done pulses once; busy falls after STOP.
REQ-026 Loop without header:
- Stimulus: same frame, one_shot=0.
- Response: after the first frame, the sequence repeats point 0x12 directly after the 0x56 ack slot; no START and no headers; frame_done every 18 slots.
REQ-027 Deferred swap:
- Stimulus: mid-frame, write 3 new points and swap_req with wr_len=3.
- Response: wr_ready=0 until the frame boundary; the next frame sends the 3 new points; the old frame completes intact.
REQ-028 scl gating:
- Stimulus: scl toggling 1/0 every clk.
- Response: sda changes only on scl==0 cycles; the slot count equals REQ-025.
REQ-029 Reset and boundaries:
- Stimulus: assert Not_Rst=0 during a point word.
- Response: next edge sda=11, busy=0.
- After re-enable with no swap: active_len=0 and the FSM stays in IDLE.
- wr_len=2**AW+5 clamps to 2**AW.
